seg_scan_decoder: RTL and testbench
===================================

Name: seg_scan_decoder

Overview:
- Receive side of the multiplexed 8-digit seven-segment scan interface.
- Samples the time-multiplexed anode/cathode pair, rejects ghosting by requiring a settled window, and decodes each lit digit back to its hex nibble.
- Rebuilds the 32-bit displayed value and pulses when a complete 8-digit frame has been seen.
- Used as a loopback/self-check monitor beside the display driver and as the capture end when scan lines come from another board.

Parameters:
- SETTLE_CYCLES, 4: consecutive identical samples required before a capture. Legal range 1..255; the counter is 8 bits.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- anode  in  8  digit enables, active-low one-hot; anode[i] selects nibble i (anode[0] -> value[3:0])
- cathode  in  8  segments, active-low; cathode[7]=dp (ignored), cathode[6:0]={g,f,e,d,c,b,a}
- value  out  32  last decoded nibble per digit
- digit_valid  out  8  bit i set when nibble i holds a legally decoded glyph
- frame_valid  out  1  one-cycle pulse, all 8 digits captured since last pulse
- seg_error  out  1  sticky: settled cathode pattern not a legal glyph
- anode_error  out  1  sticky: settled anode has more than one low bit

Behaviour:
- Reset (rst=0, async): value=0, digit_valid=0, seen mask=0, frame_valid=0, seg_error=0, anode_error=0, sample register=all ones (blank), stable count=0.
- Every edge: sample register s_q <= {anode,cathode}.
  - If the incoming sample != s_q: count <= 0.
  - Else if count != SETTLE_CYCLES: count <= count+1.
  - count saturates at SETTLE_CYCLES, so there is exactly one capture per stable window.
- Capture condition: incoming sample == s_q and count == SETTLE_CYCLES-1.
- Latency: if a new combination is applied before edge 0 and held, outputs update at edge SETTLE_CYCLES.
  - A change during the window restarts it; no capture occurs.
- Capture action by anode class:
  - All ones (blank): no update, no error.
  - Exactly one low bit at index i, cathode[6:0] legal: value[4i+3:4i] <= nibble; digit_valid[i] <= 1; seen[i] <= 1.
  - Exactly one low bit, cathode illegal: seg_error <= 1; digit_valid[i] <= 0; nibble unchanged; seen[i] <= 1 (the digit was scanned).
  - Two or more low bits: anode_error <= 1; nothing else changes.
- Legal glyphs, cathode[6:0] hex -> nibble:
  - 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7
  - 00->8, 10->9, 08->A, 03->b, 46->C, 21->d, 06->E, 0E->F
  - Any other pattern is illegal.
- Frame:
  - On a capture where (seen | capture bit) == 8'hFF: seen <= 0 and frame_valid <= 1 for exactly the next cycle.
  - Otherwise frame_valid <= 0.
  - Revisiting a digit already in seen does not complete a frame; the newer nibble overwrites the older one.
- Errors stay set until reset.
- value and digit_valid are not cleared at a frame boundary.
- Reset asserted mid-window or mid-frame: everything clears immediately. After release, the first capture needs a full settled window.

Test Plan:
- Reset: hold rst=0, toggle inputs -> all outputs 0; release with anode=FF -> no capture, frame_valid never pulses.
- Settle timing, SETTLE_CYCLES=4: anode=FE, cathode=FF&{1,0x24} held from before edge 0 -> value[3:0]=2, digit_valid=01 at edge 4, not earlier. Same input changed at edge 2 for one cycle -> no capture until 4 edges after it restores.
- Full frame: scan anode FE..7F, each held 6 cycles, glyphs for 0x1234ABCD (digit0=D ... digit7=1) -> value=32'h1234ABCD, digit_valid=FF, one frame_valid pulse the cycle after the digit-7 capture. A second identical scan gives exactly one more pulse.
- Illegal glyph: anode=FB, cathode[6:0]=7F -> seg_error=1, digit_valid[2]=0, value[11:8] unchanged, seen[2] set. A subsequent legal 0x46 on digit 2 -> digit_valid[2]=1, value[11:8]=C, seg_error stays 1.
- Multi-anode: anode=FC stable -> anode_error=1, value, digit_valid and seen unchanged. A glitch of fewer than SETTLE_CYCLES cycles on anode=FC -> anode_error stays 0.
- Async reset mid-frame: after digits 0..5 are captured, pulse rst low between edges -> immediate clear. Then scan digits 6,7 only -> no frame_valid.

Source files
------------

// File: rtl/seg_scan_decoder.sv
// Receive side of a multiplexed 8-digit seven-segment scan bus: waits for a settled
// anode/cathode pair, decodes the lit digit back to hex and rebuilds the 32-bit value.
module seg_scan_decoder #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  anode,
    input  logic [7:0]  cathode,
    output logic [31:0] value,
    output logic [7:0]  digit_valid,
    output logic        frame_valid,
    output logic        seg_error,
    output logic        anode_error
);

    localparam logic [7:0] CNT_MAX = 8'(SETTLE_CYCLES);
    localparam logic [7:0] CAP_AT  = 8'(SETTLE_CYCLES - 1);

    // Returns {legal, nibble} for a 7-bit active-low {g,f,e,d,c,b,a} pattern.
    function automatic logic [4:0] glyph_decode(input logic [6:0] seg);
        logic [4:0] r;
        case (seg)
            7'h40:   r = {1'b1, 4'h0};
            7'h79:   r = {1'b1, 4'h1};
            7'h24:   r = {1'b1, 4'h2};
            7'h30:   r = {1'b1, 4'h3};
            7'h19:   r = {1'b1, 4'h4};
            7'h12:   r = {1'b1, 4'h5};
            7'h02:   r = {1'b1, 4'h6};
            7'h78:   r = {1'b1, 4'h7};
            7'h00:   r = {1'b1, 4'h8};
            7'h10:   r = {1'b1, 4'h9};
            7'h08:   r = {1'b1, 4'hA};
            7'h03:   r = {1'b1, 4'hB};
            7'h46:   r = {1'b1, 4'hC};
            7'h21:   r = {1'b1, 4'hD};
            7'h06:   r = {1'b1, 4'hE};
            7'h0E:   r = {1'b1, 4'hF};
            default: r = {1'b0, 4'h0};
        endcase
        return r;
    endfunction

    logic [15:0] sample;
    logic [15:0] s_q;
    logic [7:0]  cnt_q, cnt_d;
    logic        same;
    logic        capture;

    logic [31:0] value_q, value_d;
    logic [7:0]  dv_q, dv_d;
    logic [7:0]  seen_q, seen_d;
    logic        fv_q, fv_d;
    logic        seg_err_q, seg_err_d;
    logic        an_err_q, an_err_d;

    logic [7:0]  low;
    logic        blank;
    logic        multi;
    logic        single;
    logic [7:0]  hit;
    logic [4:0]  dec;
    logic        legal;
    logic [3:0]  nib;

    assign sample  = {anode, cathode};
    assign same    = (sample == s_q);
    assign capture = same && (cnt_q == CAP_AT);

    // Classification uses the registered sample, which equals the input whenever capture fires.
    assign low    = ~s_q[15:8];
    assign blank  = (low == 8'h00);
    assign multi  = |(low & (low - 8'd1));
    assign single = !blank && !multi;
    assign dec    = glyph_decode(s_q[6:0]);
    assign legal  = dec[4];
    assign nib    = dec[3:0];

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_hit
            assign hit[gi] = capture && single && low[gi];
        end
    endgenerate

    always_comb begin
        cnt_d = cnt_q;
        if (!same) begin
            cnt_d = 8'd0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_comb begin
        value_d   = value_q;
        dv_d      = dv_q;
        seen_d    = seen_q;
        fv_d      = 1'b0;
        seg_err_d = seg_err_q;
        an_err_d  = an_err_q;
        if (capture && multi) begin
            an_err_d = 1'b1;
        end else if (|hit) begin
            // An illegal glyph still counts as the digit having been scanned.
            seen_d = seen_q | hit;
            if (legal) begin
                dv_d = dv_q | hit;
                for (int i = 0; i < 8; i++) begin
                    if (hit[i]) begin
                        value_d[i*4 +: 4] = nib;
                    end
                end
            end else begin
                seg_err_d = 1'b1;
                dv_d      = dv_q & ~hit;
            end
            if ((seen_q | hit) == 8'hFF) begin
                seen_d = 8'h00;
                fv_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_q       <= 16'hFFFF;
            cnt_q     <= 8'd0;
            value_q   <= 32'h0;
            dv_q      <= 8'h00;
            seen_q    <= 8'h00;
            fv_q      <= 1'b0;
            seg_err_q <= 1'b0;
            an_err_q  <= 1'b0;
        end else begin
            s_q       <= sample;
            cnt_q     <= cnt_d;
            value_q   <= value_d;
            dv_q      <= dv_d;
            seen_q    <= seen_d;
            fv_q      <= fv_d;
            seg_err_q <= seg_err_d;
            an_err_q  <= an_err_d;
        end
    end

    assign value       = value_q;
    assign digit_valid = dv_q;
    assign frame_valid = fv_q;
    assign seg_error   = seg_err_q;
    assign anode_error = an_err_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: settle timing, frame assembly, glyph and anode errors.
module tb_seg_scan_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  anode = 8'hFF;
    logic [7:0]  cathode = 8'hFF;
    logic [31:0] value;
    logic [7:0]  digit_valid;
    logic        frame_valid;
    logic        seg_error;
    logic        anode_error;

    int compared = 0;
    int mismatched = 0;
    int fv_cnt = 0;
    int fv_base;

    seg_scan_decoder #(.SETTLE_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .anode(anode), .cathode(cathode),
        .value(value), .digit_valid(digit_valid), .frame_valid(frame_valid),
        .seg_error(seg_error), .anode_error(anode_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (frame_valid === 1'b1) fv_cnt++;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        logic [6:0] g;
        case (n)
            4'h0: g = 7'h40; 4'h1: g = 7'h79; 4'h2: g = 7'h24; 4'h3: g = 7'h30;
            4'h4: g = 7'h19; 4'h5: g = 7'h12; 4'h6: g = 7'h02; 4'h7: g = 7'h78;
            4'h8: g = 7'h00; 4'h9: g = 7'h10; 4'hA: g = 7'h08; 4'hB: g = 7'h03;
            4'hC: g = 7'h46; 4'hD: g = 7'h21; 4'hE: g = 7'h06; default: g = 7'h0E;
        endcase
        return g;
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic show(input logic [7:0] an, input logic [6:0] seg, input int cycles);
        anode   = an;
        cathode = {1'b1, seg};
        step(cycles);
    endtask

    task automatic scan_digit(input int d, input logic [31:0] v);
        logic [7:0] an;
        an = ~(8'h01 << d);
        show(an, glyph(v[d*4 +: 4]), 6);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            anode   = 8'hFE;
            cathode = {1'b1, glyph(4'(i))};
            step(1);
        end
        compared++;
        if ({value, digit_valid, frame_valid, seg_error, anode_error} !== 43'h0) begin
            mismatched++;
            $display("FAIL reset_hold: value=%h dv=%h fv=%b se=%b ae=%b required all 0",
                     value, digit_valid, frame_valid, seg_error, anode_error);
        end
        anode = 8'hFF; cathode = 8'hFF;
        step(1);
        rst = 1'b1;
        step(10);
        compared++;
        if (fv_cnt !== 0 || value !== 32'h0 || digit_valid !== 8'h00) begin
            mismatched++;
            $display("FAIL reset_release: fv_cnt=%0d value=%h dv=%h required 0/0/0",
                     fv_cnt, value, digit_valid);
        end
        $display("reset: done");
    endtask

    task automatic test_settle;
        anode = 8'hFE; cathode = {1'b1, 7'h24};
        step(4);
        compared++;
        if (digit_valid !== 8'h00) begin
            mismatched++;
            $display("FAIL settle_early: dv=%h required 00", digit_valid);
        end
        step(1);
        compared++;
        if (digit_valid !== 8'h01 || value[3:0] !== 4'h2) begin
            mismatched++;
            $display("FAIL settle_capture: dv=%h nib0=%h required 01/2", digit_valid, value[3:0]);
        end
        anode = 8'hFD; cathode = {1'b1, 7'h30};
        step(2);
        cathode = {1'b1, 7'h19};
        step(1);
        cathode = {1'b1, 7'h30};
        step(4);
        compared++;
        if (digit_valid[1] !== 1'b0 || value[7:4] !== 4'h0) begin
            mismatched++;
            $display("FAIL settle_glitch_early: dv1=%b nib1=%h required 0/0", digit_valid[1], value[7:4]);
        end
        step(1);
        compared++;
        if (digit_valid[1] !== 1'b1 || value[7:4] !== 4'h3) begin
            mismatched++;
            $display("FAIL settle_glitch_capture: dv1=%b nib1=%h required 1/3", digit_valid[1], value[7:4]);
        end
        $display("settle: value=%h dv=%h", value, digit_valid);
    endtask

    task automatic test_full_frame;
        logic [31:0] v;
        v = 32'h1234ABCD;
        fv_base = fv_cnt;
        for (int d = 0; d < 7; d++) scan_digit(d, v);
        anode = 8'h7F; cathode = {1'b1, glyph(v[31:28])};
        step(4);
        compared++;
        if (frame_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL frame_early: fv=%b required 0", frame_valid);
        end
        step(1);
        compared++;
        if (frame_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL frame_pulse: fv=%b required 1", frame_valid);
        end
        step(1);
        compared++;
        if (frame_valid !== 1'b0 || value !== v || digit_valid !== 8'hFF || fv_cnt - fv_base !== 1) begin
            mismatched++;
            $display("FAIL frame_result: fv=%b value=%h dv=%h pulses=%0d required 0/%h/FF/1",
                     frame_valid, value, digit_valid, fv_cnt - fv_base, v);
        end
        for (int d = 0; d < 8; d++) scan_digit(d, v);
        compared++;
        if (fv_cnt - fv_base !== 2) begin
            mismatched++;
            $display("FAIL frame_second: pulses=%0d required 2", fv_cnt - fv_base);
        end
        $display("full_frame: value=%h pulses=%0d", value, fv_cnt - fv_base);
    endtask

    task automatic test_illegal;
        logic [31:0] v;
        v = 32'h1234ABCD;
        show(8'hFB, 7'h7F, 6);
        compared++;
        if (seg_error !== 1'b1 || digit_valid !== 8'hFB || value !== v) begin
            mismatched++;
            $display("FAIL illegal_glyph: se=%b dv=%h value=%h required 1/FB/%h",
                     seg_error, digit_valid, value, v);
        end
        fv_base = fv_cnt;
        for (int d = 0; d < 8; d++) if (d != 2) scan_digit(d, v);
        compared++;
        if (fv_cnt - fv_base !== 1) begin
            mismatched++;
            $display("FAIL illegal_seen: pulses=%0d required 1", fv_cnt - fv_base);
        end
        show(8'hFB, 7'h46, 6);
        compared++;
        if (seg_error !== 1'b1 || digit_valid !== 8'hFF || value !== 32'h1234ACCD || anode_error !== 1'b0) begin
            mismatched++;
            $display("FAIL illegal_recover: se=%b dv=%h value=%h ae=%b required 1/FF/1234ACCD/0",
                     seg_error, digit_valid, value, anode_error);
        end
        $display("illegal: value=%h se=%b", value, seg_error);
    endtask

    task automatic test_multi_anode;
        logic [31:0] v;
        v = 32'h1234ACCD;
        show(8'hFF, 7'h7F, 6);
        show(8'hFC, glyph(4'h5), 2);
        show(8'hFF, 7'h7F, 6);
        compared++;
        if (anode_error !== 1'b0) begin
            mismatched++;
            $display("FAIL multi_glitch: ae=%b required 0", anode_error);
        end
        show(8'hFC, glyph(4'h5), 6);
        compared++;
        if (anode_error !== 1'b1 || value !== v || digit_valid !== 8'hFF) begin
            mismatched++;
            $display("FAIL multi_stable: ae=%b value=%h dv=%h required 1/%h/FF",
                     anode_error, value, digit_valid, v);
        end
        fv_base = fv_cnt;
        for (int d = 3; d < 8; d++) scan_digit(d, v);
        compared++;
        if (fv_cnt - fv_base !== 0) begin
            mismatched++;
            $display("FAIL multi_seen_partial: pulses=%0d required 0", fv_cnt - fv_base);
        end
        scan_digit(0, v);
        scan_digit(1, v);
        compared++;
        if (fv_cnt - fv_base !== 1) begin
            mismatched++;
            $display("FAIL multi_seen_complete: pulses=%0d required 1", fv_cnt - fv_base);
        end
        $display("multi_anode: ae=%b value=%h", anode_error, value);
    endtask

    task automatic test_async_reset;
        logic [31:0] v;
        v = 32'hE7F98650;
        show(8'hFF, 7'h7F, 2);
        for (int d = 0; d < 6; d++) scan_digit(d, v);
        compared++;
        if (value !== 32'h12F98650) begin
            mismatched++;
            $display("FAIL async_pre: value=%h required 12F98650", value);
        end
        anode = 8'hFF; cathode = 8'hFF;
        step(1);
        #2 rst = 1'b0;
        #1;
        compared++;
        if ({value, digit_valid, frame_valid, seg_error, anode_error} !== 43'h0) begin
            mismatched++;
            $display("FAIL async_clear: value=%h dv=%h fv=%b se=%b ae=%b required all 0",
                     value, digit_valid, frame_valid, seg_error, anode_error);
        end
        #1 rst = 1'b1;
        step(1);
        fv_base = fv_cnt;
        anode = 8'hBF; cathode = {1'b1, glyph(4'h7)};
        step(4);
        compared++;
        if (digit_valid !== 8'h00) begin
            mismatched++;
            $display("FAIL async_window_early: dv=%h required 00", digit_valid);
        end
        step(2);
        compared++;
        if (digit_valid !== 8'h40 || value !== 32'h07000000) begin
            mismatched++;
            $display("FAIL async_window: dv=%h value=%h required 40/07000000", digit_valid, value);
        end
        scan_digit(7, v);
        compared++;
        if (fv_cnt - fv_base !== 0 || digit_valid !== 8'hC0 || value !== 32'hE7000000) begin
            mismatched++;
            $display("FAIL async_no_frame: pulses=%0d dv=%h value=%h required 0/C0/E7000000",
                     fv_cnt - fv_base, digit_valid, value);
        end
        $display("async_reset: value=%h dv=%h", value, digit_valid);
    endtask

    initial begin
        test_reset();
        test_settle();
        test_full_frame();
        test_illegal();
        test_multi_anode();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
